// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 packet assembler:
//   - ps2_state_e   : packet assembler FSM states
//   - PKT_BYTES_MAX : largest packet the assembler can be built for
//   - IDX_W         : width of the in-packet byte index
//   - sat_inc8      : saturating 8-bit increment used by the drop counter
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam int PKT_BYTES_MAX = 8;
  localparam int IDX_W         = $clog2(PKT_BYTES_MAX);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } ps2_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// ---------------------------------------------------------------------------
// ps2_timeout_counter
// Counts consecutive enabled cycles and flags when TIMEOUT of them have
// elapsed. TIMEOUT = 0 disables the counter entirely (expired never rises).
//
// Ports:
//   clk     in  clock, rising edge
//   reset   in  synchronous active-high reset
//   clear   in  restart the count from zero
//   enable  in  count this cycle
//   expired out high during the TIMEOUT-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module ps2_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused_ok;
      assign w_unused_ok = &{1'b0, clk, reset, clear, enable};
      assign expired     = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_count;

      // Combinational so the abort lands on the edge that closes the
      // TIMEOUT-th idle cycle, not one cycle later.
      assign expired = enable && (r_count == CW'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ps2_packet_assembler.sv
// ---------------------------------------------------------------------------
// ps2_packet_assembler
// Groups a stream of PS/2 bytes into PKT_BYTES-byte packets. A packet starts
// with a byte whose bit SYNC_BIT is set; bytes seen while hunting for sync
// are discarded. A completed packet is loaded into a single output register
// with valid/ready handshake; if that register is still occupied the new
// packet is dropped and overflow pulses. A partial packet is abandoned after
// TIMEOUT idle cycles between bytes.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   in_byte     in   [7:0] received byte
//   in_valid    in   in_byte valid (always accepted)
//   out_ready   in   consumer takes out_packet this cycle
//   out_packet  out  [8*PKT_BYTES-1:0] packet, first byte in MSBs
//   out_valid   out  out_packet holds an unconsumed packet
//   overflow    out  one-cycle pulse when a completed packet is dropped
//   drop_count  out  [7:0] saturating count of discard/abort/drop events
// ---------------------------------------------------------------------------
module ps2_packet_assembler
  import ps2_pkg::*;
#(
  parameter int PKT_BYTES = 3,
  parameter int SYNC_BIT  = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   out_ready,
  output logic [8*PKT_BYTES-1:0] out_packet,
  output logic                   out_valid,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam int               PW       = 8 * PKT_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  ps2_state_e       r_state;
  ps2_state_e       w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  // Holds bytes 0..PKT_BYTES-2; the last byte joins straight from in_byte.
  logic [PW-9:0]    r_asm;
  logic [PW-1:0]    w_pkt;

  logic [PW-1:0]    r_out_packet;
  logic             r_out_valid;
  logic             r_overflow;
  logic [7:0]       r_drop_count;

  logic             w_store;
  logic             w_complete;
  logic             w_discard;
  logic             w_abort;
  logic             w_load;
  logic             w_drop_pkt;
  logic             w_drop_evt;
  logic             w_tmo_clear;
  logic             w_tmo_enable;
  logic             w_expired;

  ps2_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_tmo_clear),
    .enable  (w_tmo_enable),
    .expired (w_expired)
  );

  assign w_tmo_clear  = in_valid || (r_state == IDLE);
  assign w_tmo_enable = (r_state == COLLECT) && !in_valid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // FSM next state and per-cycle events
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_store      = 1'b0;
    w_complete   = 1'b0;
    w_discard    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (in_byte[SYNC_BIT]) begin
            w_store      = 1'b1;
            w_idx_next   = IDX_W'(1);
            w_state_next = COLLECT;
          end else begin
            w_discard = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (r_idx == LAST_IDX) begin
            w_complete   = 1'b1;
            w_idx_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_store    = 1'b1;
            w_idx_next = r_idx + 1'b1;
          end
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_idx_next   = '0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Byte assembly: position idx maps to byte lane PKT_BYTES-1-idx.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int k = 0; k < PKT_BYTES - 1; k++) begin
        if (r_idx == IDX_W'(k)) begin
          r_asm[8*(PKT_BYTES-2-k) +: 8] <= in_byte;
        end
      end
    end
  end

  assign w_pkt = {r_asm, in_byte};

  // Output slot is free if empty or being consumed this same cycle.
  assign w_load     = w_complete && (!r_out_valid || out_ready);
  assign w_drop_pkt = w_complete && r_out_valid && !out_ready;
  assign w_drop_evt = w_discard || w_abort || w_drop_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_packet <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow <= w_drop_pkt;
      if (w_load) begin
        r_out_packet <= w_pkt;
        r_out_valid  <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop_evt) begin
        r_drop_count <= sat_inc8(r_drop_count);
      end
    end
  end

  assign out_packet = r_out_packet;
  assign out_valid  = r_out_valid;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
